cmp51_operand_sequencer: RTL and testbench

//  Initiator side of the 5-input min-index comparator interface (COMPARATOR_51).

---
 rtl/cmp51_pkg.sv | 15 +
 rtl/cmp51_ref_min.sv | 26 ++
 rtl/cmp51_operand_sequencer.sv | 141 ++++++++++++++
 tb/tb_cmp51_operand_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp51_pkg.sv
// Shared constants and FSM encoding for the COMPARATOR_51 operand sequencer.
package cmp51_pkg;

   localparam int unsigned N_IN  = 5;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 10;

   typedef enum logic [1:0] {
      StLoad,
      StSettle,
      StCapture,
      StHold
   } state_e;

endpackage

// File: rtl/cmp51_ref_min.sv
// Combinational reference min-index over five unsigned operands.
// On ties the lowest index wins.
module cmp51_ref_min
   import cmp51_pkg::*;
#(
   parameter int unsigned DATA_W = 6
) (
   input  logic [DATA_W-1:0] ops [N_IN],
   output logic [IDX_W-1:0]  min_idx
);

   logic [DATA_W-1:0] best;

   always_comb begin
      min_idx = '0;
      best    = ops[0];
      // Strict less-than keeps the earliest index on ties.
      for (int k = 1; k < N_IN; k++) begin
         if (ops[k] < best) begin
            best    = ops[k];
            min_idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/cmp51_operand_sequencer.sv
// Serial operand loader / result capture for a COMPARATOR_51 instance.
// Optional checker enabled by defining CMP51_SELFCHECK_EN.
module cmp51_operand_sequencer
   import cmp51_pkg::*;
#(
   parameter int unsigned DATA_W        = 6,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] cmp_i0,
   output logic [DATA_W-1:0] cmp_i1,
   output logic [DATA_W-1:0] cmp_i2,
   output logic [DATA_W-1:0] cmp_i3,
   output logic [DATA_W-1:0] cmp_i4,
   input  logic [IDX_W-1:0]  cmp_min,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_min,
   output logic [CNT_W-1:0]  out_cnt
`ifdef CMP51_SELFCHECK_EN
   ,
   output logic              chk_err,
   output logic [CNT_W-1:0]  chk_err_cnt
`endif
);

   localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

   state_e            state_q, state_d;
   logic [2:0]        slot_q, slot_d;
   logic [3:0]        settle_q, settle_d;
   logic [DATA_W-1:0] ops_q [N_IN];
   logic [IDX_W-1:0]  out_min_q;
   logic [CNT_W-1:0]  out_cnt_q;
   logic              accept, capture, done;

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      settle_d = settle_q;
      accept   = 1'b0;
      capture  = 1'b0;
      done     = 1'b0;
      in_ready = (state_q == StLoad) && !reset;
      out_valid = (state_q == StHold);
      unique case (state_q)
         StLoad: begin
            if (in_valid) begin
               accept = 1'b1;
               if (slot_q == 3'(N_IN - 1)) begin
                  slot_d = '0;
                  if (SETTLE_CYCLES == 0) begin
                     state_d = StCapture;
                  end else begin
                     state_d  = StSettle;
                     settle_d = SettleInit;
                  end
               end else begin
                  slot_d = slot_q + 3'd1;
               end
            end
         end
         StSettle: begin
            settle_d = settle_q - 4'd1;
            if (settle_q <= 4'd1) state_d = StCapture;
         end
         StCapture: begin
            capture = 1'b1;
            state_d = StHold;
         end
         StHold: begin
            if (out_ready) begin
               done    = 1'b1;
               state_d = StLoad;
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StLoad;
         slot_q    <= '0;
         settle_q  <= '0;
         out_min_q <= '0;
         out_cnt_q <= '0;
         for (int k = 0; k < N_IN; k++) ops_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         settle_q <= settle_d;
         for (int k = 0; k < N_IN; k++) begin
            if (accept && slot_q == 3'(k)) ops_q[k] <= in_data;
         end
         if (capture) out_min_q <= cmp_min;
         if (done) out_cnt_q <= out_cnt_q + CNT_W'(1);
      end
   end

   assign cmp_i0  = ops_q[0];
   assign cmp_i1  = ops_q[1];
   assign cmp_i2  = ops_q[2];
   assign cmp_i3  = ops_q[3];
   assign cmp_i4  = ops_q[4];
   assign out_min = out_min_q;
   assign out_cnt = out_cnt_q;

`ifdef CMP51_SELFCHECK_EN
   logic [IDX_W-1:0] ref_idx;
   logic             chk_err_q;
   logic [CNT_W-1:0] chk_cnt_q;

   cmp51_ref_min #(
      .DATA_W (DATA_W)
   ) u_ref_min (
      .ops     (ops_q),
      .min_idx (ref_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         chk_err_q <= 1'b0;
         chk_cnt_q <= '0;
      end else if (capture && (cmp_min != ref_idx)) begin
         chk_err_q <= 1'b1;
         if (chk_cnt_q != '1) chk_cnt_q <= chk_cnt_q + CNT_W'(1);
      end else if (done) begin
         chk_err_q <= 1'b0;
      end
   end

   assign chk_err     = chk_err_q;
   assign chk_err_cnt = chk_cnt_q;
`endif

endmodule

// File: tb/tb_cmp51_operand_sequencer.sv
// Scoreboard bench: unit 0 uses SETTLE_CYCLES=2 with a 2-cycle comparator model,
// unit 1 uses SETTLE_CYCLES=0 with a zero-delay comparator model.
module tb_cmp51_operand_sequencer;

   typedef struct {
      int mn;
      int t;
      int err;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset     [2];
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic [5:0] in_data   [2];
   logic [5:0] cmp_i     [2][5];
   logic [2:0] cmp_min   [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [2:0] out_min   [2];
   logic [9:0] out_cnt   [2];
`ifdef CMP51_SELFCHECK_EN
   logic       chk_err     [2];
   logic [9:0] chk_err_cnt [2];
`endif

   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   int   settle_of [2] = '{2, 0};
   logic [5:0] mdl [2][5];
   int   wr_k [2];
   int   exp_cnt [2];
   int   exp_err_cnt [2];
   bit   prev_v [2];
   bit   force4 = 1'b0;
   bit   rand_rdy = 1'b0;
   exp_t exp_q [2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cmp51_operand_sequencer #(.DATA_W(6), .SETTLE_CYCLES(2)) u_dut_a (
      .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .cmp_i0(cmp_i[0][0]), .cmp_i1(cmp_i[0][1]), .cmp_i2(cmp_i[0][2]),
      .cmp_i3(cmp_i[0][3]), .cmp_i4(cmp_i[0][4]), .cmp_min(cmp_min[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_min(out_min[0]),
      .out_cnt(out_cnt[0])
`ifdef CMP51_SELFCHECK_EN
      , .chk_err(chk_err[0]), .chk_err_cnt(chk_err_cnt[0])
`endif
   );

   cmp51_operand_sequencer #(.DATA_W(6), .SETTLE_CYCLES(0)) u_dut_b (
      .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .cmp_i0(cmp_i[1][0]), .cmp_i1(cmp_i[1][1]), .cmp_i2(cmp_i[1][2]),
      .cmp_i3(cmp_i[1][3]), .cmp_i4(cmp_i[1][4]), .cmp_min(cmp_min[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_min(out_min[1]),
      .out_cnt(out_cnt[1])
`ifdef CMP51_SELFCHECK_EN
      , .chk_err(chk_err[1]), .chk_err_cnt(chk_err_cnt[1])
`endif
   );

   // Index of the smallest value, first occurrence on ties.
   function automatic int min_of(input logic [5:0] v [5]);
      int best = 0;
      for (int k = 1; k < 5; k++) if (v[k] < v[best]) best = k;
      return best;
   endfunction

   // Behavioural COMPARATOR_51 models: unit 0 delayed two clocks, unit 1 immediate.
   logic [2:0] comb_a, a_d1, a_d2;
   always_comb comb_a = 3'(min_of(cmp_i[0]));
   always @(posedge clk) begin
      a_d1 <= comb_a;
      a_d2 <= a_d1;
   end
   always_comb cmp_min[0] = force4 ? 3'd4 : a_d2;
   always_comb cmp_min[1] = 3'(min_of(cmp_i[1]));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
   endtask

   always @(posedge clk) if (rand_rdy) #1 out_ready[0] = ($urandom_range(0, 3) != 0);

   // Monitor: checks every cycle a result is presented, pops on handshake.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (!reset[u] && out_valid[u]) begin
            if (exp_q[u].size() == 0) begin
               check($sformatf("u%0d_unexpected_valid", u), 1, 0);
            end else begin
               if (!prev_v[u])
                  check($sformatf("u%0d_latency", u), cyc, exp_q[u][0].t + settle_of[u] + 1);
               check($sformatf("u%0d_out_min", u), int'(out_min[u]), exp_q[u][0].mn);
               check($sformatf("u%0d_out_cnt", u), int'(out_cnt[u]), exp_cnt[u]);
               check($sformatf("u%0d_in_ready_in_hold", u), int'(in_ready[u]), 0);
               for (int k = 0; k < 5; k++)
                  check($sformatf("u%0d_cmp_i%0d", u, k), int'(cmp_i[u][k]), int'(mdl[u][k]));
`ifdef CMP51_SELFCHECK_EN
               check($sformatf("u%0d_chk_err", u), int'(chk_err[u]), exp_q[u][0].err);
               check($sformatf("u%0d_chk_err_cnt", u), int'(chk_err_cnt[u]), exp_err_cnt[u]);
`endif
               if (out_ready[u]) begin
                  void'(exp_q[u].pop_front());
                  exp_cnt[u] = (exp_cnt[u] + 1) % 1024;
               end
            end
         end
         prev_v[u] = reset[u] ? 1'b0 : out_valid[u];
      end
   end

   task automatic do_reset(input int u);
      reset[u] = 1'b1;
      in_valid[u] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("u%0d_rst_in_ready", u), int'(in_ready[u]), 0);
      check($sformatf("u%0d_rst_out_valid", u), int'(out_valid[u]), 0);
      check($sformatf("u%0d_rst_out_cnt", u), int'(out_cnt[u]), 0);
      check($sformatf("u%0d_rst_out_min", u), int'(out_min[u]), 0);
      for (int k = 0; k < 5; k++) check($sformatf("u%0d_rst_cmp_i%0d", u, k), int'(cmp_i[u][k]), 0);
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) mdl[u][k] = '0;
      wr_k[u] = 0;
      exp_q[u].delete();
      exp_cnt[u] = 0;
      exp_err_cnt[u] = 0;
      reset[u] = 1'b0;
   endtask

   task automatic send(input int u, input logic [5:0] d);
      bit rdy = 1'b0;
      int c = 0;
      int n = 0;
      exp_t e;
      in_valid[u] = 1'b1;
      in_data[u] = d;
      do begin
         @(negedge clk);
         rdy = in_ready[u];
         c = cyc;
         @(posedge clk);
         n++;
      end while (!rdy && n < 200);
      #1;
      in_valid[u] = 1'b0;
      if (!rdy) begin
         check($sformatf("u%0d_accept_timeout", u), 0, 1);
         return;
      end
      mdl[u][wr_k[u]] = d;
      wr_k[u]++;
      if (wr_k[u] == 5) begin
         wr_k[u] = 0;
         e.t = c + 1;
         e.mn = (u == 0 && force4) ? 4 : min_of(mdl[u]);
         e.err = (e.mn != min_of(mdl[u])) ? 1 : 0;
         if (e.err != 0 && exp_err_cnt[u] < 1023) exp_err_cnt[u]++;
         exp_q[u].push_back(e);
      end
   endtask

   task automatic send_vec(input int u, input int a, input int b, input int c, input int d,
                           input int e);
      send(u, 6'(a)); send(u, 6'(b)); send(u, 6'(c)); send(u, 6'(d)); send(u, 6'(e));
   endtask

   task automatic send_rand_vec(input int u);
      int lim = ($urandom_range(0, 1) != 0) ? 3 : 63;
      for (int k = 0; k < 5; k++) send(u, 6'($urandom_range(0, lim)));
   endtask

   task automatic wait_idle(input int u);
      int n = 0;
      while (exp_q[u].size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q[u].size() != 0) check($sformatf("u%0d_drain_timeout", u), 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         reset[u] = 1'b1;
         in_valid[u] = 1'b0;
         in_data[u] = '0;
         out_ready[u] = 1'b1;
      end
      fork
         do_reset(0);
         do_reset(1);
      join

      send_vec(0, 10, 20, 3, 40, 50);
      wait_idle(0);
      send_vec(0, 7, 7, 7, 7, 7);
      send_vec(0, 63, 63, 63, 63, 63);
      wait_idle(0);

      // Result held under backpressure while the next vector is already offered.
      out_ready[0] = 1'b0;
      send_vec(0, 33, 12, 40, 12, 9);
      fork
         begin
            repeat (6) @(posedge clk);
            #1 out_ready[0] = 1'b1;
         end
         send_vec(0, 5, 4, 3, 2, 1);
      join
      wait_idle(0);

      send(0, 6'd1); send(0, 6'd2); send(0, 6'd0);
      do_reset(0);
      send_vec(0, 30, 31, 32, 29, 33);
      wait_idle(0);

      rand_rdy = 1'b1;
      repeat (30) send_rand_vec(0);
      wait_idle(0);
      rand_rdy = 1'b0;
      #1 out_ready[0] = 1'b1;
      wait_idle(0);

`ifdef CMP51_SELFCHECK_EN
      force4 = 1'b1;
      send_vec(0, 1, 2, 3, 4, 5);
      wait_idle(0);
      force4 = 1'b0;
      send_vec(0, 9, 8, 9, 8, 9);
      wait_idle(0);
`endif

      send_vec(1, 10, 20, 3, 40, 50);
      wait_idle(1);
      repeat (1024) begin
         send_rand_vec(1);
         wait_idle(1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
